muldiv_unit: RTL

Multiply/divide unit for the EX stage of the 5-stage MIPS pipeline. It owns the HI/LO register pair and executes MULT/MULTU/DIV/DIVU over multiple cycles. Its `busy` output drives the hazard unit's multiply-busy input, which stalls any younger mul/div, MTHI/MTLO or MFHI/MFLO in ID until `busy` clears. HI/LO values are presented combinationally from registers for MFHI/MFLO in EX.

---
 rtl/muldiv_unit.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit owning the HI/LO pair for the EX stage.
// Optional MADD/MADDU/MSUB/MSUBU accumulate ops are compiled in with MULDIV_MADD_EN.
module muldiv_unit #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        hilo_we,
  input  logic        hilo_sel,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [3:0] MUL_N = 4'(MUL_CYCLES);
  localparam logic [3:0] DIV_N = 4'(DIV_CYCLES);

  // Handshake: start/hilo_we are only honoured while busy is low; busy is a
  // pure register decode, so the hazard unit sees no path from start.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_LAST = 2'd2
  } state_t;

  logic [3:0]  r_cnt;
  logic [31:0] r_res_hi;
  logic [31:0] r_res_lo;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  state_t      w_state;
  logic [3:0]  w_cnt_n;
  logic [31:0] w_res_hi_n;
  logic [31:0] w_res_lo_n;
  logic [31:0] w_hi_n;
  logic [31:0] w_lo_n;

  logic        w_legal;
  logic        w_is_div;
  logic        w_signed;
  logic [63:0] w_mul_a;
  logic [63:0] w_mul_b;
  logic [63:0] w_prod;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic [31:0] w_uq;
  logic [31:0] w_ur;
  logic [31:0] w_quot;
  logic [31:0] w_rem;
  logic [63:0] w_result;

  always_comb begin
    if (r_cnt == 4'd0)      w_state = ST_IDLE;
    else if (r_cnt == 4'd1) w_state = ST_LAST;
    else                    w_state = ST_BUSY;
  end

  assign busy = (r_cnt != 4'd0);
  assign hi   = r_hi;
  assign lo   = r_lo;

  // Odd opcodes are the unsigned variants for every op group.
  assign w_signed = ~op[0];
  assign w_is_div = ~op[2] & op[1];

  // Low 64 bits of the product of the extended operands are the exact result.
  assign w_mul_a = {{32{w_signed & src_a[31]}}, src_a};
  assign w_mul_b = {{32{w_signed & src_b[31]}}, src_b};
  assign w_prod  = w_mul_a * w_mul_b;

  // Signed divide by magnitudes; 0x80000000 / -1 wraps back to 0x80000000.
  assign w_a_neg = w_signed & src_a[31];
  assign w_b_neg = w_signed & src_b[31];
  assign w_abs_a = w_a_neg ? (32'd0 - src_a) : src_a;
  assign w_abs_b = w_b_neg ? (32'd0 - src_b) : src_b;

  always_comb begin
    w_uq   = 32'd0;
    w_ur   = 32'd0;
    w_quot = 32'hFFFF_FFFF;
    w_rem  = src_a;
    if (src_b != 32'd0) begin
      w_uq   = w_abs_a / w_abs_b;
      w_ur   = w_abs_a % w_abs_b;
      w_quot = (w_a_neg ^ w_b_neg) ? (32'd0 - w_uq) : w_uq;
      w_rem  = w_a_neg ? (32'd0 - w_ur) : w_ur;
    end
  end

`ifdef MULDIV_MADD_EN
  logic [63:0] w_acc;

  assign w_legal = 1'b1;
  assign w_acc   = op[1] ? ({r_hi, r_lo} - w_prod) : ({r_hi, r_lo} + w_prod);

  always_comb begin
    if (op[2])         w_result = w_acc;
    else if (w_is_div) w_result = {w_rem, w_quot};
    else               w_result = w_prod;
  end
`else
  assign w_legal = ~op[2];

  always_comb begin
    if (w_is_div) w_result = {w_rem, w_quot};
    else          w_result = w_prod;
  end
`endif

  always_comb begin
    w_cnt_n    = r_cnt;
    w_res_hi_n = r_res_hi;
    w_res_lo_n = r_res_lo;
    w_hi_n     = r_hi;
    w_lo_n     = r_lo;
    case (w_state)
      ST_IDLE: begin
        // start takes priority, so a coincident MT write is dropped.
        if (start) begin
          if (w_legal) begin
            w_res_hi_n = w_result[63:32];
            w_res_lo_n = w_result[31:0];
            w_cnt_n    = w_is_div ? DIV_N : MUL_N;
          end
        end else if (hilo_we) begin
          if (hilo_sel) w_hi_n = src_a;
          else          w_lo_n = src_a;
        end
      end
      ST_BUSY: begin
        w_cnt_n = r_cnt - 4'd1;
      end
      ST_LAST: begin
        w_cnt_n = 4'd0;
        w_hi_n  = r_res_hi;
        w_lo_n  = r_res_lo;
      end
      default: begin
        w_cnt_n = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt    <= 4'd0;
      r_res_hi <= 32'd0;
      r_res_lo <= 32'd0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
    end else begin
      r_cnt    <= w_cnt_n;
      r_res_hi <= w_res_hi_n;
      r_res_lo <= w_res_lo_n;
      r_hi     <= w_hi_n;
      r_lo     <= w_lo_n;
    end
  end

endmodule
